// File: rtl/dmem_axi_bridge.sv
// dmem_axi_bridge: turns single-word TIM dmem requests into AXI4-Lite master transactions,
// one outstanding at a time, and returns the result with an error pulse on non-OKAY responses.
package dmem_axi_pkg;
    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;
    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;
endpackage

module dmem_axi_bridge
    import dmem_axi_pkg::*;
#(
    parameter logic [2:0] prot_data  = 3'b000,
    parameter logic [2:0] prot_instr = 3'b100
) (
    input  logic        rst,
    input  logic        clk,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output logic        err,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_awaddr,
    output logic [2:0]  m_awprot,
    output logic        m_wvalid,
    input  logic        m_wready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_bvalid,
    output logic        m_bready,
    input  logic [1:0]  m_bresp,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    output logic [2:0]  m_arprot,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp
);
    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  prot_q, prot_d;
    logic [1:0]  resp_q, resp_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        prot_d    = prot_q;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: if (dmem_in.mem_valid) begin
                addr_d    = dmem_in.mem_addr;
                wdata_d   = dmem_in.mem_wdata;
                wstrb_d   = dmem_in.mem_wstrb;
                prot_d    = dmem_in.mem_instr ? prot_instr : prot_data;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = |dmem_in.mem_wstrb ? WADDR : RADDR;
            end
            WADDR: begin
                // AW and W complete independently; leave once both have handshaken
                aw_done_d = aw_done_q | m_awready;
                w_done_d  = w_done_q | m_wready;
                state_d   = (aw_done_d && w_done_d) ? WRESP : WADDR;
            end
            WRESP: if (m_bvalid) begin
                resp_d  = m_bresp;
                rdata_d = '0;
                state_d = DONE;
            end
            RADDR: state_d = m_arready ? RDATA : RADDR;
            RDATA: if (m_rvalid) begin
                resp_d  = m_rresp;
                rdata_d = m_rdata;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            prot_q    <= '0;
            resp_q    <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            prot_q    <= prot_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign m_awvalid = (state_q == WADDR) && !aw_done_q;
    assign m_wvalid  = (state_q == WADDR) && !w_done_q;
    assign m_arvalid = (state_q == RADDR);
    assign m_bready  = (state_q == WRESP);
    assign m_rready  = (state_q == RDATA);
    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_awprot  = prot_q;
    assign m_arprot  = prot_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;

    assign err                = (state_q == DONE) && |resp_q;
    assign dmem_out.mem_ready = (state_q == DONE);
    assign dmem_out.mem_rdata = ((state_q == DONE) && !err) ? rdata_q : '0;
endmodule
